prio_grant_decoder_amisha: RTL and testbench

Sequential grant decoder that consumes the 3-bit priority code produced by the 4-request priority encoder and turns it back into a one-hot grant on lines g[4:1].
- Each accepted code holds its grant for a fixed number of cycles.
- The grant then releases with a one-cycle done pulse before the next code is accepted.
- The block sits downstream of the encoder, on the arbiter's grant path, and drives the requesting agents.

---
 rtl/prio_grant_decoder_amisha.sv | 116 +++++++++++
 tb/tb_prio_grant_decoder_amisha.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_grant_decoder_amisha.sv
// prio_grant_decoder_amisha
//   Turns a 3-bit priority code from the upstream 4-request encoder back into a
//   one-hot grant. Each grant is held for HOLD_CYCLES cycles or until an early
//   release. It then ends with a one-cycle done pulse before the next code is
//   accepted.
//
// Ports
//   clk_amisha        in   system clock, rising edge
//   rst_n_amisha      in   asynchronous active-low reset
//   y_amisha[2:0]     in   priority code: 0 none, 1..4 request r[k] won, 5..7 illegal
//   valid_amisha      in   y_amisha is valid this cycle
//   ready_amisha      out  a code can be accepted this cycle (IDLE)
//   release_amisha    in   early release, only honoured while granting
//   g_amisha[3:0]     out  registered one-hot grant, bit k-1 <=> code k
//   done_amisha       out  one-cycle pulse in the cycle after a grant ends
//   err_amisha        out  one-cycle pulse after an illegal code is accepted
//   grant_cnt_amisha  out  grants issued, modulo 256

module prio_grant_decoder_amisha #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk_amisha,
    input  logic       rst_n_amisha,
    input  logic [2:0] y_amisha,
    input  logic       valid_amisha,
    output logic       ready_amisha,
    input  logic       release_amisha,
    output logic [3:0] g_amisha,
    output logic       done_amisha,
    output logic       err_amisha,
    output logic [7:0] grant_cnt_amisha
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    // The counter is loaded with HOLD_CYCLES-1 so that the GRANT cycle that
    // sees zero is the last one, giving exactly HOLD_CYCLES grant cycles.
    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] g_q, g_d;
    logic       err_q, err_d;
    logic [7:0] gcnt_q, gcnt_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        g_d     = g_q;
        err_d   = 1'b0;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            StIdle: begin
                if (valid_amisha) begin
                    case (y_amisha)
                        3'd0: ;
                        3'd1, 3'd2, 3'd3, 3'd4: begin
                            unique case (y_amisha)
                                3'd1:    g_d = 4'b0001;
                                3'd2:    g_d = 4'b0010;
                                3'd3:    g_d = 4'b0100;
                                default: g_d = 4'b1000;
                            endcase
                            hold_d  = HoldLoad;
                            gcnt_d  = gcnt_q + 8'd1;
                            state_d = StGrant;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StGrant: begin
                if (hold_q == 8'd0 || release_amisha) begin
                    g_d     = 4'b0000;
                    state_d = StRelease;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                g_d     = 4'b0000;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state_q <= StIdle;
            hold_q  <= 8'd0;
            g_q     <= 4'b0000;
            err_q   <= 1'b0;
            gcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            g_q     <= g_d;
            err_q   <= err_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign ready_amisha     = (state_q == StIdle);
    assign done_amisha      = (state_q == StRelease);
    assign g_amisha         = g_q;
    assign err_amisha       = err_q;
    assign grant_cnt_amisha = gcnt_q;

endmodule

// File: tb/tb_prio_grant_decoder_amisha.sv
module tb_prio_grant_decoder_amisha;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] y;
    logic       valid;
    logic       rel;
    logic       ready;
    logic [3:0] g;
    logic       done;
    logic       err;
    logic [7:0] cnt;

    // Second instance with a one-cycle hold, used for the counter wrap run.
    logic [2:0] y1;
    logic       valid1;
    logic       ready1;
    logic [3:0] g1;
    logic       done1;
    logic       err1;
    logic [7:0] cnt1;

    always #5 clk = ~clk;

    prio_grant_decoder_amisha #(.HOLD_CYCLES(HOLD)) dut (
        .clk_amisha      (clk),
        .rst_n_amisha    (rst_n),
        .y_amisha        (y),
        .valid_amisha    (valid),
        .ready_amisha    (ready),
        .release_amisha  (rel),
        .g_amisha        (g),
        .done_amisha     (done),
        .err_amisha      (err),
        .grant_cnt_amisha(cnt)
    );

    prio_grant_decoder_amisha #(.HOLD_CYCLES(1)) dut1 (
        .clk_amisha      (clk),
        .rst_n_amisha    (rst_n),
        .y_amisha        (y1),
        .valid_amisha    (valid1),
        .ready_amisha    (ready1),
        .release_amisha  (1'b0),
        .g_amisha        (g1),
        .done_amisha     (done1),
        .err_amisha      (err1),
        .grant_cnt_amisha(cnt1)
    );

    int checks = 0;
    int errors = 0;

    // Timeline model: n is the index of the current cycle. A grant accepted at
    // the edge that starts cycle t_acc is visible in cycles t_acc..t_end-1,
    // cycle t_end is the done cycle, and the block is idle after it.
    int         n = 0;
    int         t_acc = 0;
    int         t_end = 0;
    int         err_edge = -10;
    bit         have = 0;
    logic [3:0] m_oh = 4'b0000;
    int         m_cnt = 0;
    bit         acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        return !have || n > t_end;
    endfunction

    task automatic model_reset();
        have     = 0;
        m_cnt    = 0;
        err_edge = -10;
        m_oh     = 4'b0000;
    endtask

    task automatic model_edge();
        int yi;
        yi  = int'(y);
        acc = 0;
        if (rst_n) begin
            if (exp_ready() && valid) begin
                if (yi >= 1 && yi <= 4) begin
                    have  = 1;
                    t_acc = n + 1;
                    t_end = n + 1 + HOLD;
                    m_oh  = 4'(1 << (yi - 1));
                    m_cnt = (m_cnt + 1) % 256;
                    acc   = 1;
                end else if (yi >= 5) begin
                    err_edge = n + 1;
                end
            end else if (have && n < t_end && rel) begin
                t_end = n + 1;
            end
        end
        n++;
    endtask

    task automatic check_all();
        logic [3:0] eg;
        eg = (have && n >= t_acc && n < t_end) ? m_oh : 4'b0000;
        chk("g", 32'(g), 32'(eg));
        chk("done", 32'(done), 32'(have && n == t_end));
        chk("ready", 32'(ready), 32'(exp_ready()));
        chk("err", 32'(err), 32'(n == err_edge));
        chk("grant_cnt", 32'(cnt), 32'(m_cnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Present a code with valid held until it is taken.
    task automatic send(input logic [2:0] code);
        int k;
        valid = 1'b1;
        y     = code;
        k     = 0;
        do begin
            cycle();
            k++;
        end while (!acc && k < 20);
        chk("send_taken", 32'(acc), 32'd1);
        valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("reset_cnt1", 32'(cnt1), 32'd0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        int c0;
        rst_n  = 1'b0;
        y      = 3'd0;
        valid  = 1'b0;
        rel    = 1'b0;
        y1     = 3'd0;
        valid1 = 1'b0;
        #1;
        check_all();
        repeat (2) cycle();
        @(negedge clk);
        n++;
        rst_n = 1'b1;

        // Single code 3, valid for one cycle.
        valid = 1'b1;
        y     = 3'd3;
        cycle();
        chk("t1_g", 32'(g), 32'h4);
        valid = 1'b0;
        repeat (6) cycle();
        chk("t1_cnt", 32'(cnt), 32'd1);

        // Codes 1, 2, 4 back to back with valid held while busy.
        c0 = n;
        send(3'd1);
        chk("t2_g1", 32'(g), 32'h1);
        c0 = n;
        send(3'd2);
        chk("t2_space", 32'(n - c0), 32'(HOLD + 2));
        chk("t2_g2", 32'(g), 32'h2);
        send(3'd4);
        chk("t2_g4", 32'(g), 32'h8);
        repeat (6) cycle();
        chk("t2_cnt", 32'(cnt), 32'd4);

        // Zero and illegal codes on consecutive cycles.
        valid = 1'b1;
        y = 3'd0; cycle();
        y = 3'd5; cycle();
        y = 3'd7; cycle();
        chk("t3_err7", 32'(err), 32'd1);
        valid = 1'b0;
        cycle();
        chk("t3_err_off", 32'(err), 32'd0);

        // Early release on the second grant cycle.
        send(3'd4);
        cycle();
        rel = 1'b1;
        cycle();
        chk("t4_g_clear", 32'(g), 32'd0);
        chk("t4_done", 32'(done), 32'd1);
        rel = 1'b0;
        cycle();
        chk("t4_ready", 32'(ready), 32'd1);

        // Reset during the third grant cycle.
        send(3'd2);
        cycle();
        cycle();
        pulse_reset();
        chk("t5_cnt", 32'(cnt), 32'd0);
        send(3'd1);
        chk("t5_g", 32'(g), 32'h1);
        repeat (6) cycle();

        // Counter wrap on the one-cycle-hold instance.
        valid1 = 1'b1;
        y1     = 3'd1;
        for (int i = 0; i < 256; i++) begin
            k = 0;
            while (!ready1 && k < 5) begin
                cycle();
                k++;
            end
            chk("w_ready", 32'(ready1), 32'd1);
            cycle();
            chk("w_g", 32'(g1), 32'h1);
            chk("w_cnt", 32'(cnt1), 32'((i + 1) % 256));
            cycle();
            chk("w_g_off", 32'(g1), 32'd0);
            chk("w_done", 32'(done1), 32'd1);
        end
        valid1 = 1'b0;
        chk("w_wrap", 32'(cnt1), 32'd0);
        chk("w_err", 32'(err1), 32'd0);

        // Random traffic against the timeline model.
        for (int i = 0; i < 3000; i++) begin
            valid = 1'($urandom % 2);
            y     = 3'($urandom % 8);
            rel   = ($urandom % 4) == 0;
            if ($urandom % 200 == 0) pulse_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
